alu_arbiter: RTL

//  Shares one combinational alu instance between NUM_REQ requesters (decode, address-gen, CSR unit).

---
 rtl/alu_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Each result is held in a one-entry response buffer, tagged with the owning requester's index.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*OP_W-1:0]    req_op,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_b,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_result,
    input  logic                       rsp_ready,
    output logic [15:0]                busy_cycles
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_result;
    logic [15:0]         r_busy;

    logic                w_can_issue;
    logic                w_found;
    logic                w_transfer;
    logic [ID_W-1:0]     w_grant;
    logic [ID_W-1:0]     w_scan;
    logic [OP_W-1:0]     w_op;
    logic [31:0]         w_alu_control;
    logic [DATA_W-1:0]   w_operand1;
    logic [DATA_W-1:0]   w_operand2;
    logic [DATA_W-1:0]   w_alu_result;

    assign w_can_issue = (r_state == EMPTY) || rsp_ready;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_scan]) begin
                w_found = 1'b1;
                w_grant = w_scan;
            end
        end
    end

    assign w_transfer = w_found && w_can_issue && rst_n;

    always_comb begin
        req_ready = '0;
        if (w_transfer) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_op       = '0;
        w_operand1 = '0;
        w_operand2 = '0;
        if (w_transfer) begin
            w_op       = req_op[w_grant*OP_W +: OP_W];
            w_operand1 = req_a[w_grant*DATA_W +: DATA_W];
            w_operand2 = req_b[w_grant*DATA_W +: DATA_W];
        end
    end

    assign w_alu_control = {{(32-OP_W){1'b0}}, w_op};

    // Undefined op codes produce zero, like the shared ALU's default branch.
    always_comb begin
        case (w_alu_control)
            32'd0:   w_alu_result = w_operand1 + w_operand2;
            32'd1:   w_alu_result = w_operand1 - w_operand2;
            32'd2:   w_alu_result = w_operand1 & w_operand2;
            32'd3:   w_alu_result = w_operand1 | w_operand2;
            32'd4:   w_alu_result = w_operand1 ^ w_operand2;
            default: w_alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY: if (w_transfer) w_next_state = FULL;
            FULL:  if (rsp_ready && !w_transfer) w_next_state = EMPTY;
            default: w_next_state = EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid   = (r_state == FULL);
        rsp_id      = r_rsp_id;
        rsp_result  = r_rsp_result;
        busy_cycles = r_busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
        end else if (w_transfer) begin
            r_rr_ptr     <= (w_grant == ID_W'(NUM_REQ-1)) ? '0 : w_grant + 1'b1;
            r_rsp_id     <= w_grant;
            r_rsp_result <= w_alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else if ((r_state == FULL) && !rsp_ready && (r_busy != 16'hFFFF)) begin
            r_busy <= r_busy + 16'd1;
        end
    end
endmodule
